// File: rtl/noc_injector.sv
// Packet injector for a mesh NoC: takes a routed request plus its payload words,
// buffers them, then streams HEAD, BODY... and TAIL flits into the router's local port.
module noc_injector #(
    parameter int WIDTH    = 32,
    parameter int X_SIZE   = 4,
    parameter int Y_SIZE   = 4,
    parameter int MAX_LEN  = 8,
    parameter int X_BITS   = $clog2(X_SIZE),
    parameter int Y_BITS   = $clog2(Y_SIZE),
    parameter int LEN_BITS = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [X_BITS-1:0]   my_x,
    input  logic [Y_BITS-1:0]   my_y,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [X_BITS-1:0]   req_dest_x,
    input  logic [Y_BITS-1:0]   req_dest_y,
    input  logic [LEN_BITS-1:0] req_len,
    input  logic                wr_valid,
    input  logic [WIDTH-1:0]    wr_data,
    output logic                wr_ready,
    output logic                flit_valid,
    input  logic                flit_ready,
    output logic [WIDTH-1:0]    flit_data,
    output logic [1:0]          flit_type,
    output logic                err,
    output logic [15:0]         pkt_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HEAD,
        BODY
    } state_t;

    localparam logic [1:0] TYPE_BODY = 2'b00;
    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b10;
    localparam int IDX_BITS = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t              state, state_next;
    logic [X_BITS-1:0]   dest_x, dest_x_next;
    logic [Y_BITS-1:0]   dest_y, dest_y_next;
    logic [LEN_BITS-1:0] len, len_next;
    logic [LEN_BITS-1:0] idx, idx_next;
    logic [LEN_BITS-1:0] k, k_next;
    logic [LEN_BITS-1:0] k_inc;
    logic [LEN_BITS-1:0] len_last;
    logic                flit_valid_next;
    logic [WIDTH-1:0]    flit_data_next;
    logic [1:0]          flit_type_next;
    logic                err_next;
    logic [15:0]         pkt_count_next;
    logic                req_legal;
    logic [WIDTH-1:0]    head_word;
    logic [WIDTH-1:0]    buffer [MAX_LEN];

    assign req_ready = (state == IDLE);
    assign wr_ready  = (state == LOAD);

    assign req_legal = (req_len != '0) && (int'(req_len) <= MAX_LEN) &&
                       (int'(req_dest_x) < X_SIZE) && (int'(req_dest_y) < Y_SIZE);

    assign len_last  = len - LEN_BITS'(1);
    assign k_inc     = k + LEN_BITS'(1);
    // Header fields packed LSB-first, upper bits zero-filled by the cast.
    assign head_word = WIDTH'({len, my_y, my_x, dest_y, dest_x});

    always_comb begin
        state_next      = state;
        dest_x_next     = dest_x;
        dest_y_next     = dest_y;
        len_next        = len;
        idx_next        = idx;
        k_next          = k;
        flit_valid_next = flit_valid;
        flit_data_next  = flit_data;
        flit_type_next  = flit_type;
        err_next        = 1'b0;
        pkt_count_next  = pkt_count;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_legal) begin
                        dest_x_next = req_dest_x;
                        dest_y_next = req_dest_y;
                        len_next    = req_len;
                        idx_next    = '0;
                        state_next  = LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (wr_valid) begin
                    idx_next = idx + LEN_BITS'(1);
                    if (idx == len_last) begin
                        state_next      = HEAD;
                        flit_valid_next = 1'b1;
                        flit_data_next  = head_word;
                        flit_type_next  = TYPE_HEAD;
                    end
                end
            end
            HEAD: begin
                if (flit_ready) begin
                    state_next     = BODY;
                    k_next         = '0;
                    flit_data_next = buffer[0];
                    flit_type_next = (len_last == '0) ? TYPE_TAIL : TYPE_BODY;
                end
            end
            BODY: begin
                // flit_valid is always high here, so flit_ready alone completes a handshake.
                if (flit_ready) begin
                    if (k == len_last) begin
                        state_next      = IDLE;
                        flit_valid_next = 1'b0;
                        flit_data_next  = '0;
                        flit_type_next  = TYPE_BODY;
                        pkt_count_next  = pkt_count + 16'd1;
                    end else begin
                        k_next         = k_inc;
                        flit_data_next = buffer[k_inc[IDX_BITS-1:0]];
                        flit_type_next = (k_inc == len_last) ? TYPE_TAIL : TYPE_BODY;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dest_x     <= '0;
            dest_y     <= '0;
            len        <= '0;
            idx        <= '0;
            k          <= '0;
            flit_valid <= 1'b0;
            flit_data  <= '0;
            flit_type  <= TYPE_BODY;
            err        <= 1'b0;
            pkt_count  <= 16'd0;
        end else begin
            state      <= state_next;
            dest_x     <= dest_x_next;
            dest_y     <= dest_y_next;
            len        <= len_next;
            idx        <= idx_next;
            k          <= k_next;
            flit_valid <= flit_valid_next;
            flit_data  <= flit_data_next;
            flit_type  <= flit_type_next;
            err        <= err_next;
            pkt_count  <= pkt_count_next;
        end
    end

    // Payload storage needs no reset; slots are always written before they are read.
    always_ff @(posedge clk) begin
        if (state == LOAD && wr_valid) begin
            buffer[idx[IDX_BITS-1:0]] <= wr_data;
        end
    end

endmodule
